load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit for the RISC-V CPU example. It produces the `memory_data` word consumed by the writeback stage. It takes an effective address and store data from execute, runs a single-outstanding request/ready transaction on the data-memory port, and aligns and extends the load result. While a transaction is in flight it stalls the pipeline, and it reports misaligned, illegal-size and timeout faults.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: cycles spent in REQ without `mem_ready` before a timeout fault; 0 disables the timeout.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: execute stage presents a memory instruction this cycle.
- `is_load` / `is_store` input 1 each: access kind; never both set.
- `funct3` input 3: size/sign field (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `address` input `address_t`: effective byte address (ALU result).
- `store_data` input `word_t`: rs2 value.
- `load_data` output `word_t`: aligned, extended load result to writeback; registered.
- `done` output 1: one-cycle pulse when the access completes or faults.
- `stall` output 1: hold the pipeline.
- `fault` output 1: asserted with `done` when the access faulted.
- `fault_cause` output 2: 01 misaligned, 10 illegal size, 11 timeout; 00 when `fault`=0.
- `mem_req` output 1: request to data memory.
- `mem_we` output 1: 1 = write.
- `mem_addr` output `address_t`: word-aligned address, `{address[31:2],2'b00}`.
- `mem_wdata` output `word_t`: write data, replicated across lanes.
- `mem_wstrb` output 4: byte enables for a write; 0000 for a read.
- `mem_ready` input 1: memory accepts the request; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` input `word_t`: read word.

## Operation
- The state machine has four states: IDLE, REQ, RESP and FAULT.
- IDLE, with `start` and (`is_load` or `is_store`) set, classifies the access:
  - Illegal size goes to FAULT with cause 10. Illegal means load `funct3` ∈ {011, 110, 111}, or store `funct3[2]`=1.
  - Misalignment goes to FAULT with cause 01. Misaligned means H/HU with `address[0]`=1, or W with `address[1:0]`≠0. Illegal size takes priority over misalignment.
  - Otherwise the access goes to REQ. The following are latched: `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb`, `funct3`, `address[1:0]`. The timeout counter clears.
- Store lane formatting:
  - SB: `mem_wdata` = {4{sd[7:0]}}, `mem_wstrb` = 0001<<a[1:0].
  - SH: `mem_wdata` = {2{sd[15:0]}}, `mem_wstrb` = 0011<<a[1:0].
  - SW: `mem_wdata` = sd, `mem_wstrb` = 1111.
- REQ:
  - `mem_req`=1. All `mem_*` outputs are held stable.
  - `mem_ready`=1 goes to RESP. For a load, `load_data` is captured from `mem_rdata`.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES` ≠ 0), the state goes to FAULT with cause 11 and `mem_req` drops.
- Load formatting: take `mem_rdata >> (8*a[1:0])`.
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W passes through.
- RESP: `done`=1 for one cycle, then IDLE.
  - `load_data` holds its value until the next load completes. Stores do not modify it.
  - `start` is ignored in RESP because it is the same instruction.
- FAULT: `done`=1, `fault`=1 and `fault_cause` valid for one cycle, then IDLE. No memory access is made for cause 01 or 10.
- `stall` = (IDLE & `start` & (`is_load`|`is_store`)) | REQ. `stall` is 0 in RESP and FAULT, so the pipeline advances at the end of that cycle.
- `start` with neither `is_load` nor `is_store` set: no action, no stall.

## Timing
- Reset: state IDLE, and every output 0: `load_data`, `done`, `fault`, `fault_cause`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`.
- Reset mid-REQ: `mem_req` is 0 from the reset edge onward. No `done` is produced.
- The state machine never has more than one outstanding request.
- Accepted at cycle T:
  - `mem_req` is high from T+1.
  - If `mem_ready` is seen at cycle T+k (k ≥ 1), `done` and `load_data` are valid at T+k+1.
  - Minimum latency from accept to `done` is 2 cycles.
- Misaligned or illegal access at cycle T: `done` and `fault` at T+1.
- Timeout: with `mem_ready` never asserted, `done` with cause 11 arrives at T+1+`TIMEOUT_CYCLES`.
- `mem_ready` sampled in the same cycle the timeout is reached: `mem_ready` wins, and the access completes normally.
- `mem_ready` outside REQ is ignored.

## Test plan
- LW at 0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` on the first REQ cycle:
  - `mem_addr`=0x100, `mem_wstrb`=0000.
  - `done` 2 cycles after accept, with `load_data`=0xDEADBEEF.
  - `stall` is high for exactly 2 cycles.
- LB at 0x103, then LBU at 0x103, with `mem_rdata`=0x80123456: `load_data`=0xFFFFFF80, then 0x00000080.
- SH at 0x202, `store_data`=0x0000ABCD, `mem_ready` delayed 3 cycles:
  - `mem_addr`=0x200, `mem_wdata`=0xABCDABCD, `mem_wstrb`=1100.
  - All held stable for 4 REQ cycles.
  - `load_data` is unchanged.
- LW at 0x101: no `mem_req`; next cycle `done`=1, `fault`=1, `fault_cause`=01. Load with `funct3`=011 at 0x101: `fault_cause`=10.
- `TIMEOUT_CYCLES`=4, `mem_ready` held 0:
  - `mem_req` high for 4 cycles.
  - Then `done`+`fault` with cause 11, and `mem_req`=0.
  - Repeat with `mem_ready` asserted on the 4th REQ cycle: normal completion.
- Reset asserted during REQ:
  - Next cycle `mem_req`=0 and all outputs are 0.
  - A new LW after reset release completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/ready port of the load/store unit
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit with single-outstanding memory access
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [31:0]          address,
    input  logic [31:0]          store_data,
    output logic [31:0]          load_data,
    output logic                 done,
    output logic                 stall,
    output logic                 fault,
    output logic [1:0]           fault_cause,
    load_store_unit_if.master    mem
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1; the fault fires on the cycle it would reach TIMEOUT_CYCLES.
    localparam int unsigned   CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_SIZE     = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;
    logic [1:0]    cause_q;
    logic [1:0]    cause_next;
    logic          access;
    logic          illegal;
    logic          misaligned;
    logic          accept;
    logic          timeout_hit;
    logic [31:0]   fmt_wdata;
    logic [3:0]    fmt_wstrb;
    logic [31:0]   shifted;
    logic [31:0]   fmt_rdata;

    // Classify the incoming access; illegal size outranks misalignment in the FSM.
    always_comb begin
        access      = start & (is_load | is_store);
        illegal     = is_load ? ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111))
                              : funct3[2];
        misaligned  = ((funct3[1:0] == 2'b01) & address[0])
                    | ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00));
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    end

    // Replicate store data across byte lanes and build the byte enables; reads get no enables.
    always_comb begin
        fmt_wdata = '0;
        fmt_wstrb = '0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    fmt_wdata = {4{store_data[7:0]}};
                    fmt_wstrb = 4'b0001 << address[1:0];
                end
                2'b01: begin
                    fmt_wdata = {2{store_data[15:0]}};
                    fmt_wstrb = 4'b0011 << address[1:0];
                end
                default: begin
                    fmt_wdata = store_data;
                    fmt_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Shift the addressed lane down and extend according to the latched size/sign field.
    always_comb begin
        shifted = mem.mem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  fmt_rdata = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  fmt_rdata = {24'h000000, shifted[7:0]};
            3'b001:  fmt_rdata = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  fmt_rdata = {16'h0000, shifted[15:0]};
            default: fmt_rdata = shifted;
        endcase
    end

    // Next-state and state-decoded outputs; mem_ready wins over a same-cycle timeout.
    always_comb begin
        state_next  = state;
        cause_next  = cause_q;
        accept      = 1'b0;
        stall       = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        fault_cause = 2'b00;
        mem.mem_req = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (illegal) begin
                        state_next = FAULT;
                        cause_next = CAUSE_SIZE;
                    end else if (misaligned) begin
                        state_next = FAULT;
                        cause_next = CAUSE_MISALIGN;
                    end else begin
                        state_next = REQ;
                        accept     = 1'b1;
                    end
                end
            end
            REQ: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    state_next = RESP;
                end else if (timeout_hit) begin
                    state_next = FAULT;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            RESP: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                done        = 1'b1;
                fault       = 1'b1;
                fault_cause = cause_q;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and fault-cause registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cause_q <= 2'b00;
        end else begin
            state   <= state_next;
            cause_q <= cause_next;
        end
    end

    // Request latch, timeout counter and load result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem.mem_addr  <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_wdata <= '0;
            mem.mem_wstrb <= '0;
            f3_q          <= '0;
            lane_q        <= '0;
            cnt           <= '0;
            load_data     <= '0;
        end else begin
            if (accept) begin
                mem.mem_addr  <= {address[31:2], 2'b00};
                mem.mem_we    <= is_store;
                mem.mem_wdata <= fmt_wdata;
                mem.mem_wstrb <= fmt_wstrb;
                f3_q          <= funct3;
                lane_q        <= address[1:0];
                cnt           <= '0;
            end
            if (state == REQ) begin
                if (mem.mem_ready) begin
                    if (!mem.mem_we) begin
                        load_data <= fmt_rdata;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
